// File: rtl/subst_layer_seq.sv
// ASCON substitution layer, processed COLS_PER_CYCLE columns at a time.
// State words are packed as state[w][j]: w = 0..4 selects x0..x4, j = 0..63
// selects the bit column. Each column {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 as MSB)
// goes through one 5-bit S-box and is written back to the same bit positions.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start_i; state_o holds the last result
// RUN   | one chunk of columns substituted in place per edge
// DONE  | one-cycle done_o pulse; start_i here is accepted back-to-back

module ascon_sbox (
   input  logic [4:0] sbox_i,
   output logic [4:0] sbox_o
);
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   // table lookup, purely combinational
   assign sbox_o = SBOX[sbox_i];
endmodule

module subst_layer_seq #(
   parameter int COLS_PER_CYCLE = 8
) (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             start_i,
   input  logic [4:0][63:0] state_i,
   output logic [4:0][63:0] state_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam int NCHUNK = 64 / COLS_PER_CYCLE;
   // a single-chunk configuration still gets a 1-bit counter that stays at 0
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t             fsm_q;
   logic [CW-1:0]    chunk_q;
   logic [4:0][63:0] work_q;
   logic [4:0][63:0] work_d;
   logic             busy_q;
   logic             done_q;

   logic [5:0]       col    [COLS_PER_CYCLE];
   logic [4:0]       sb_in  [COLS_PER_CYCLE];
   logic [4:0]       sb_out [COLS_PER_CYCLE];

   generate
      for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
         assign col[i]   = 6'((int'(chunk_q) * COLS_PER_CYCLE) + i);
         assign sb_in[i] = {work_q[0][col[i]], work_q[1][col[i]], work_q[2][col[i]],
                            work_q[3][col[i]], work_q[4][col[i]]};
         ascon_sbox u_sbox (
            .sbox_i (sb_in[i]),
            .sbox_o (sb_out[i])
         );
      end
   endgenerate

   // working register with the current chunk's columns replaced by S-box outputs
   always_comb begin
      work_d = work_q;
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         for (int w = 0; w < 5; w++) begin
            work_d[w][col[i]] = sb_out[i][4-w];
         end
      end
   end

   // sequencer: FSM, chunk counter, working register and registered flags
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         chunk_q <= '0;
         work_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE, DONE: begin
               if (start_i) begin
                  work_q  <= state_i;
                  chunk_q <= '0;
                  fsm_q   <= RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  fsm_q   <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               work_q <= work_d;
               if (chunk_q == LAST_CHUNK) begin
                  chunk_q <= '0;
                  fsm_q   <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  chunk_q <= chunk_q + CW'(1);
               end
            end
            default: begin
               fsm_q  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = work_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_subst_layer_seq.sv
// Bench for subst_layer_seq: three instances (8, 1 and 64 columns per cycle)
// checked against a bitsliced ASCON S-layer model through a result queue.
module tb_subst_layer_seq;
   typedef logic [4:0][63:0] st_t;
   typedef struct {
      st_t in;
      st_t exp;
   } vec_t;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk;
   logic rst_n;
   logic start  [3];
   st_t  st_in  [3];
   st_t  st_out [3];
   logic busy   [3];
   logic done   [3];

   int   checks = 0;
   int   errors = 0;

   st_t  vecs [$];
   st_t  exps [$];
   st_t  sb   [$];
   vec_t tbl  [3];

   subst_layer_seq #(.COLS_PER_CYCLE(8)) u_dut8 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[0]), .state_i(st_in[0]),
      .state_o(st_out[0]), .busy_o(busy[0]), .done_o(done[0]));
   subst_layer_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[1]), .state_i(st_in[1]),
      .state_o(st_out[1]), .busy_o(busy[1]), .done_o(done[1]));
   subst_layer_seq #(.COLS_PER_CYCLE(64)) u_dut64 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[2]), .state_i(st_in[2]),
      .state_o(st_out[2]), .busy_o(busy[2]), .done_o(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // reference: ASCON substitution layer in bitsliced form over whole words
   function automatic st_t model(input st_t s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      st_t r;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
      return r;
   endfunction

   function automatic st_t rand_st();
      st_t s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
      return s;
   endfunction

   // expected state after k of 8 chunks: low k*8 columns substituted
   function automatic st_t partial(input st_t v, input st_t full, input int k);
      logic [63:0] m;
      st_t r;
      m = (k >= 8) ? ONES : ((64'h1 << (k * 8)) - 64'h1);
      for (int w = 0; w < 5; w++) r[w] = (full[w] & m) | (v[w] & ~m);
      return r;
   endfunction

   task automatic chk(input string nm, input st_t act, input st_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   // back-to-back run of vecs/exps on instance d with start_i held high
   task automatic stream(input int d, input int lat);
      int  idx, cyc, ndone, busy_cnt, last_done, n;
      st_t exp_v;
      n = vecs.size();
      idx = 0; cyc = 0; ndone = 0; busy_cnt = 0; last_done = 0;
      @(negedge clk);
      st_in[d] = vecs[0];
      start[d] = 1'b1;
      sb.push_back(exps[0]);
      idx = 1;
      while (ndone < n && cyc < (n + 2) * (lat + 2)) begin
         @(negedge clk);
         cyc++;
         if (busy[d]) busy_cnt++;
         if (done[d]) begin
            exp_v = sb.pop_front();
            chk("result", st_out[d], exp_v);
            chk_int("latency", cyc - last_done, lat);
            chk_int("busy_cycles", busy_cnt, lat - 1);
            busy_cnt = 0;
            last_done = cyc;
            ndone++;
            if (idx < n) begin
               st_in[d] = vecs[idx];
               sb.push_back(exps[idx]);
               idx++;
            end else begin
               start[d] = 1'b0;
            end
         end else begin
            st_in[d] = rand_st();
         end
      end
      chk_int("stream_done_count", ndone, n);
      start[d] = 1'b0;
      sb.delete();
      exp_v = exps[n-1];
      repeat (3) @(negedge clk);
      chk("hold_result", st_out[d], exp_v);
      chk_int("no_extra_done", int'(done[d]), 0);
   endtask

   task automatic load_table();
      vecs.delete(); exps.delete();
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(tbl[i].in);
         exps.push_back(tbl[i].exp);
      end
   endtask

   initial begin
      st_t v, full;
      int  cyc, dcnt, bcnt;

      tbl[0].in = '0;
      tbl[0].exp = '0; tbl[0].exp[2] = ONES;
      tbl[1].in = {ONES, ONES, ONES, ONES, ONES};
      tbl[1].exp = {ONES, ONES, ONES, ONES, ONES}; tbl[1].exp[1] = 64'h0;
      tbl[2].in = '0; tbl[2].in[0] = 64'h1;
      tbl[2].exp = '0;
      tbl[2].exp[0] = 64'h1; tbl[2].exp[1] = 64'h1; tbl[2].exp[2] = ONES; tbl[2].exp[3] = 64'h1;

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0;
         st_in[d] = '0;
      end
      #22;
      for (int d = 0; d < 3; d++) begin
         chk("reset_state", st_out[d], '0);
         chk_int("reset_busy", int'(busy[d]), 0);
         chk_int("reset_done", int'(done[d]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      load_table(); stream(0, 9);
      load_table(); stream(1, 65);
      load_table(); stream(2, 2);

      // chunk order with a start pulse and new state_i during RUN
      v = rand_st();
      full = model(v);
      @(negedge clk);
      st_in[0] = v; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; st_in[0] = rand_st();
      chk("loaded", st_out[0], v);
      chk_int("run_busy0", int'(busy[0]), 1);
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) begin
            start[0] = 1'b1;
            st_in[0] = rand_st();
         end else begin
            start[0] = 1'b0;
         end
         @(negedge clk);
         chk("chunk", st_out[0], partial(v, full, k));
         chk_int("chunk_busy", int'(busy[0]), (k < 8) ? 1 : 0);
         chk_int("chunk_done", int'(done[0]), (k == 8) ? 1 : 0);
      end
      @(negedge clk);
      chk_int("done_one_cycle", int'(done[0]), 0);
      chk("result_held", st_out[0], full);

      // reset in the 4th RUN cycle
      @(negedge clk);
      st_in[0] = rand_st(); start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_int("abort_busy", int'(busy[0]), 0);
      chk_int("abort_done", int'(done[0]), 0);
      chk("abort_state", st_out[0], '0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0; bcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done[0]) dcnt++;
         if (busy[0]) bcnt++;
      end
      chk_int("no_done_after_abort", dcnt, 0);
      chk_int("idle_after_abort", bcnt, 0);

      // start already high on the first edge after reset release
      @(negedge clk);
      rst_n = 1'b0; st_in[0] = tbl[2].in; start[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!done[0] && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start[0] = 1'b0;
            st_in[0] = '0;
         end
      end
      chk_int("release_latency", cyc, 9);
      chk("release_result", st_out[0], tbl[2].exp);
      repeat (2) @(negedge clk);

      // random vectors against the model
      vecs.delete(); exps.delete();
      for (int i = 0; i < 1000; i++) begin
         v = rand_st();
         vecs.push_back(v);
         exps.push_back(model(v));
      end
      stream(0, 9);
      vecs.delete(); exps.delete();
      for (int i = 0; i < 100; i++) begin
         v = rand_st();
         vecs.push_back(v);
         exps.push_back(model(v));
      end
      stream(2, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/subst_layer_seq.md
SUBST_LAYER_SEQ -- requirements
Module: subst_layer_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 8, giving the number of S-box columns substituted per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have port clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetb_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request to substitute the state presented on state_i.
REQ-005 SHALL have port state_i  input  5x64  ASCON state words x0..x4.
REQ-006 SHALL have port state_o  output  5x64  working/result state register.
REQ-007 SHALL have port busy_o  output  1  high while substitution is in progress.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse: state_o holds the complete substituted state.

Function
REQ-009 SHALL instantiate exactly COLS_PER_CYCLE copies of the team's 5-bit ASCON S-box; no other substitution logic.
REQ-010 SHALL form column j (0..63) as the 5-bit S-box input {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 as MSB, and write output bits back to the same positions.
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 IDLE: start_i=1 at an edge SHALL load state_i into the working register, clear the chunk counter, and enter RUN. start_i=0 SHALL leave the FSM in IDLE.
REQ-013 RUN: each edge SHALL substitute columns [k*COLS_PER_CYCLE, (k+1)*COLS_PER_CYCLE-1] of the working register in place, where k is the chunk counter, then increment k.
REQ-014 The chunk counter SHALL be log2(64/COLS_PER_CYCLE) bits wide, minimum 1 bit. After the edge that processes chunk 64/COLS_PER_CYCLE-1, the FSM SHALL enter DONE and the counter SHALL wrap to 0.
REQ-015 In RUN, columns outside the current chunk SHALL NOT change.
REQ-016 start_i SHALL be ignored in RUN; state_i is sampled only on the accepting edge.
REQ-017 DONE: done_o SHALL be 1 for exactly this one cycle.
REQ-018 DONE: start_i=1 SHALL be accepted as in IDLE (load, go RUN), giving back-to-back operation; otherwise the FSM SHALL return to IDLE.
REQ-019 busy_o SHALL be 1 exactly in RUN. done_o SHALL be 1 exactly in DONE. Both SHALL be decoded from registered state only.
REQ-020 state_o SHALL drive the working register directly. After DONE it SHALL hold the result unchanged until the next accepted start.
REQ-021 Latency SHALL be 64/COLS_PER_CYCLE + 1 cycles from the accepting edge to done_o high; with default 8, done_o rises 9 edges after acceptance.
REQ-022 Throughput with continuous start_i SHALL be one substitution every 64/COLS_PER_CYCLE + 1 cycles.

Reset
REQ-023 resetb_i=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, chunk counter=0, working register=all zeros, busy_o=0, done_o=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; after release the block SHALL sit in IDLE and SHALL NOT pulse done_o.
REQ-025 The first edge after reset release with start_i=1 SHALL be accepted normally.

Verification
REQ-026 Zero state: state_i all zeros, start pulse -> after 9 edges done_o=1; x2=64'hFFFF_FFFF_FFFF_FFFF; x0, x1, x3, x4 = 0.
REQ-027 All-ones state: every word 64'hFFFF_FFFF_FFFF_FFFF -> x1=0; x0, x2, x3, x4 = all ones.
REQ-028 Single column: x0=64'h1, others 0 -> x0=64'h1, x1=64'h1, x2=all ones, x3=64'h1, x4=0.
REQ-029 Chunk order (default parameter): after the 1st RUN edge, only columns 0..7 differ from the loaded value; after the 8th RUN edge, all 64 columns are substituted; busy_o=1 for exactly 8 cycles.
REQ-030 Protocol: start_i held high continuously -> done_o pulses every 9 cycles; a start_i pulse during RUN is ignored; a new state_i during RUN is not captured.
REQ-031 Reset during RUN: assert resetb_i at the 4th RUN cycle -> busy_o and done_o drop to 0 at once, state_o=0; no done_o after release; the next start completes correctly.
REQ-032 The bench SHALL repeat REQ-026 to REQ-028 with COLS_PER_CYCLE=1 (latency 65) and COLS_PER_CYCLE=64 (latency 2), and check against a 1000-vector random reference model.
